// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dmem_arbiter_if                                             |
// | Brief  : One requester port of the data-memory arbiter: request,     |
// |          one-cycle ack, request fields and one-cycle response.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          req;
  logic          ack;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0]    size;
  logic          we;
  logic          se;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  // Requester side (CPU MEM stage or loader)
  modport master (
    output req, addr, wdata, size, we, se,
    input  ack, rvalid, rdata, err
  );

  // Arbiter side
  modport slave (
    input  req, addr, wdata, size, we, se,
    output ack, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dmem_arbiter                                                |
// | Brief  : Two-port arbiter/sequencer in front of the big-endian data  |
// |          RAM. Port 0 = CPU load/store, port 1 = program/debug loader.|
// |          Each access: ack (T), RAM enable (T+1), response (T+2);     |
// |          misaligned/illegal requests answer with err at T+1.         |
// |          Define DMEM_ARB_RR_EN for round-robin arbitration; default  |
// |          build uses fixed priority with port 0 winning.              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  dmem_arbiter_if.slave      p0,
  dmem_arbiter_if.slave      p1,
  output logic [AW-1:0]      ram_a,
  output logic [DW-1:0]      ram_di,
  output logic [1:0]         ram_size,
  output logic               ram_rw,
  output logic               ram_e,
  output logic               ram_se,
  input  wire logic [DW-1:0] ram_do,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  logic          sel;        // port owning the transaction in flight
  logic          rvalid0;
  logic          rvalid1;
  logic          err_q;
  logic [DW-1:0] rdata_q;

  logic          grant_port;
  logic          accept;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [1:0]    g_size;
  logic          g_we;
  logic          g_se;
  logic          illegal;

`ifdef DMEM_ARB_RR_EN
  logic          last_grant;

  // Round-robin pick: on contention the port not granted last wins
  always_comb begin
    grant_port = 1'b0;
    if (p0.req && p1.req) grant_port = ~last_grant;
    else                  grant_port = ~p0.req;
  end
`else
  // Fixed priority pick: port 0 wins any contention
  always_comb begin
    grant_port = ~p0.req;
  end
`endif

  // Grant decode and request-field mux; the ack is held low during reset
  always_comb begin
    accept  = (state == IDLE) && (p0.req || p1.req) && rst_n;
    g_addr  = grant_port ? p1.addr  : p0.addr;
    g_wdata = grant_port ? p1.wdata : p0.wdata;
    g_size  = grant_port ? p1.size  : p0.size;
    g_we    = grant_port ? p1.we    : p0.we;
    g_se    = grant_port ? p1.se    : p0.se;
    illegal = 1'b0;
    case (g_size)
      2'b01:   illegal = g_addr[0];
      2'b10:   illegal = (g_addr[1:0] != 2'b00);
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  assign p0.ack    = accept & ~grant_port;
  assign p1.ack    = accept &  grant_port;
  assign p0.rvalid = rvalid0;
  assign p1.rvalid = rvalid1;
  assign p0.rdata  = rvalid0 ? rdata_q : '0;
  assign p1.rdata  = rvalid1 ? rdata_q : '0;
  assign p0.err    = rvalid0 & err_q;
  assign p1.err    = rvalid1 & err_q;
  assign busy      = (state != IDLE);

  // Sequencer: RAM control and responses are all driven from flops so the
  // level-sensitive RAM write strobe never sees a combinational glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ram_a    <= '0;
      ram_di   <= '0;
      ram_size <= 2'b00;
      ram_rw   <= 1'b0;
      ram_e    <= 1'b0;
      ram_se   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          if (accept) begin
            sel <= grant_port;
`ifdef DMEM_ARB_RR_EN
            last_grant <= grant_port;
`endif
            if (illegal) begin
              // Rejected without touching the RAM; RAM outputs keep old values
              err_q   <= 1'b1;
              rdata_q <= '0;
              rvalid0 <= ~grant_port;
              rvalid1 <= grant_port;
              state   <= DONE;
            end else begin
              err_q    <= 1'b0;
              ram_a    <= g_addr;
              ram_di   <= g_wdata;
              ram_size <= g_size;
              ram_se   <= g_se;
              ram_rw   <= g_we;
              ram_e    <= 1'b1;
              state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // ram_rw dropped with ram_e so a store can never be reissued
          ram_e   <= 1'b0;
          ram_rw  <= 1'b0;
          rdata_q <= ram_rw ? '0 : ram_do;
          rvalid0 <= ~sel;
          rvalid1 <= sel;
          state   <= DONE;
        end
        DONE: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_dmem_arbiter                                             |
// | Brief  : Directed self-checking bench for dmem_arbiter with a        |
// |          512-byte big-endian RAM model.                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di;
  logic [1:0]    ram_size;
  logic          ram_rw;
  logic          ram_e;
  logic          ram_se;
  logic [DW-1:0] ram_do;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int ram_e_cnt = 0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) p0_bus ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) p1_bus ();

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0       (p0_bus),
    .p1       (p1_bus),
    .ram_a    (ram_a),
    .ram_di   (ram_di),
    .ram_size (ram_size),
    .ram_rw   (ram_rw),
    .ram_e    (ram_e),
    .ram_se   (ram_se),
    .ram_do   (ram_do),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Big-endian RAM model: combinational read, write on enabled store
  logic [7:0] mem [0:511];
  logic       mem_ready = 1'b0;

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[ram_a];
    b1 = mem[ram_a + 9'd1];
    b2 = mem[ram_a + 9'd2];
    b3 = mem[ram_a + 9'd3];
    ram_do = '0;
    case (ram_size)
      2'b00:   ram_do = ram_se ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   ram_do = ram_se ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      2'b10:   ram_do = {b0, b1, b2, b3};
      default: ram_do = '0;
    endcase
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem_ready <= 1'b1;
    end else if (ram_e && ram_rw) begin
      case (ram_size)
        2'b00: mem[ram_a] <= ram_di[7:0];
        2'b01: begin
          mem[ram_a]        <= ram_di[15:8];
          mem[ram_a + 9'd1] <= ram_di[7:0];
        end
        2'b10: begin
          mem[ram_a]        <= ram_di[31:24];
          mem[ram_a + 9'd1] <= ram_di[23:16];
          mem[ram_a + 9'd2] <= ram_di[15:8];
          mem[ram_a + 9'd3] <= ram_di[7:0];
        end
        default: ;
      endcase
    end
  end

  // Count cycles with the RAM enabled
  always @(negedge clk) begin
    if (ram_e) ram_e_cnt <= ram_e_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int port, input logic req, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [1:0] size,
                          input logic we, input logic se);
    if (port == 0) begin
      p0_bus.req = req; p0_bus.addr = addr; p0_bus.wdata = wdata;
      p0_bus.size = size; p0_bus.we = we; p0_bus.se = se;
    end else begin
      p1_bus.req = req; p1_bus.addr = addr; p1_bus.wdata = wdata;
      p1_bus.size = size; p1_bus.we = we; p1_bus.se = se;
    end
  endtask

  function automatic logic ack_of(input int port);
    return (port == 0) ? p0_bus.ack : p1_bus.ack;
  endfunction

  function automatic logic rvalid_of(input int port);
    return (port == 0) ? p0_bus.rvalid : p1_bus.rvalid;
  endfunction

  function automatic logic [31:0] rdata_of(input int port);
    return (port == 0) ? p0_bus.rdata : p1_bus.rdata;
  endfunction

  function automatic logic err_of(input int port);
    return (port == 0) ? p0_bus.err : p1_bus.err;
  endfunction

  // One request from the given port, checked against hand-computed results
  task automatic xact(input string tag, input int port, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [1:0] size,
                      input logic we, input logic se,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int cnt = 0;
    int e0;
    @(negedge clk);
    set_port(port, 1'b1, addr, wdata, size, we, se);
    #1;
    while (!ack_of(port) && cnt < 20) begin
      @(negedge clk); #1; cnt++;
    end
    check({tag, "_ack"}, ack_of(port), 1'b1);
    if (!ack_of(port)) begin
      set_port(port, 1'b0, addr, wdata, size, we, se);
      return;
    end
    check({tag, "_other_ack"}, ack_of(1 - port), 1'b0);
    e0 = ram_e_cnt;
    @(posedge clk); #1;
    set_port(port, 1'b0, addr, wdata, size, we, se);
    @(negedge clk); #1;
    if (exp_err) begin
      check({tag, "_rvalid"}, rvalid_of(port), 1'b1);
      check({tag, "_err"}, err_of(port), 1'b1);
      check({tag, "_rdata"}, rdata_of(port), 32'h0);
      check({tag, "_ram_e"}, ram_e, 1'b0);
      check({tag, "_ram_e_cnt"}, ram_e_cnt - e0, 0);
    end else begin
      check({tag, "_ram_e"}, ram_e, 1'b1);
      check({tag, "_ram_rw"}, ram_rw, we);
      check({tag, "_early_rvalid"}, rvalid_of(port), 1'b0);
      @(negedge clk); #1;
      check({tag, "_rvalid"}, rvalid_of(port), 1'b1);
      check({tag, "_err"}, err_of(port), 1'b0);
      check({tag, "_rdata"}, rdata_of(port), exp_rdata);
      check({tag, "_ram_e_off"}, {ram_e, ram_rw}, 2'b00);
      check({tag, "_ram_e_cnt"}, ram_e_cnt - e0, 1);
    end
    check({tag, "_other_rvalid"}, rvalid_of(1 - port), 1'b0);
  endtask

  initial begin
    int cnt;
    int grants;
    set_port(0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    set_port(1, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_acks", {p0_bus.ack, p1_bus.ack}, 2'b00);
    check("rst_rvalids", {p0_bus.rvalid, p1_bus.rvalid}, 2'b00);
    check("rst_errs", {p0_bus.err, p1_bus.err}, 2'b00);
    check("rst_ram_ctl", {ram_size, ram_rw, ram_e, ram_se, busy}, 6'b0);
    check("rst_ram_a", {23'h0, ram_a}, 32'h0);
    check("rst_ram_di", ram_di, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store and load-back
    xact("st_w",  0, 9'h010, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
    xact("ld_w",  0, 9'h010, 32'h0,        2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    xact("ld_h",  0, 9'h010, 32'h0,        2'b01, 1'b0, 1'b1, 1'b0, 32'hFFFFDEAD);
    xact("ld_b3", 0, 9'h013, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 32'h000000EF);

    // Byte store, load with and without sign extension
    xact("st_b",    0, 9'h021, 32'h00000080, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    xact("ld_b_se", 0, 9'h021, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'hFFFFFF80);
    xact("ld_b_ze", 0, 9'h021, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 32'h00000080);

    // Illegal requests from the loader port
    xact("mis_h",  1, 9'h033, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0);
    xact("sz11",   1, 9'h040, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0);
    xact("mis_w",  1, 9'h042, 32'h0, 2'b10, 1'b1, 1'b0, 1'b1, 32'h0);

    // Reset dropped during the ACCESS cycle of a store
    @(negedge clk);
    set_port(1, 1'b1, 9'h100, 32'h12345678, 2'b10, 1'b1, 1'b0);
    #1;
    cnt = 0;
    while (!p1_bus.ack && cnt < 20) begin
      @(negedge clk); #1; cnt++;
    end
    check("rstmid_ack", p1_bus.ack, 1'b1);
    @(posedge clk); #1;
    set_port(1, 1'b0, 9'h100, 32'h12345678, 2'b10, 1'b1, 1'b0);
    @(negedge clk); #1;
    check("rstmid_access", {ram_e, ram_rw, busy}, 3'b111);
    rst_n = 1'b0;
    #1;
    check("rstmid_ram_off", {ram_e, ram_rw}, 2'b00);
    check("rstmid_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rstmid_no_rvalid", {p0_bus.rvalid, p1_bus.rvalid}, 2'b00);
      @(negedge clk);
    end
    xact("rstmid_ld", 1, 9'h100, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0);

    // Continuous contention from both ports
    @(negedge clk);
    set_port(0, 1'b1, 9'h010, 32'h0, 2'b10, 1'b0, 1'b0);
    set_port(1, 1'b1, 9'h010, 32'h0, 2'b10, 1'b0, 1'b0);
    #1;
    grants = 0;
    cnt = 0;
    while (grants < 4 && cnt < 40) begin
      if (p0_bus.ack || p1_bus.ack) begin
        check("cont_both_ack", {p0_bus.ack, p1_bus.ack} == 2'b11, 1'b0);
`ifdef DMEM_ARB_RR_EN
        check("cont_grant", p1_bus.ack, grants[0]);
`else
        check("cont_grant", p1_bus.ack, 1'b0);
`endif
        grants++;
      end
      @(negedge clk); #1;
      cnt++;
    end
    check("cont_grant_count", grants, 4);
    p0_bus.req = 1'b0;
    p1_bus.req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 512-byte big-endian data RAM.
- Port 0 is the CPU MEM-stage load/store port. Port 1 is the program/debug loader port.
- Each accepted request is qualified for size and alignment, then issued to the RAM for exactly one cycle with registered control.
- The response is returned to the granted requester as a one-cycle pulse.
- All RAM control is registered, so the RAM's level-sensitive write never sees a combinational glitch.

Parameters:
AW, 9, byte address width (RAM depth = 2^AW bytes)
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pN_req  in  1  request, N=0,1; held high until pN_ack
pN_ack  out  1  one-cycle grant; request fields are sampled in this cycle
pN_addr  in  AW  byte address
pN_wdata  in  DW  store data, right-justified
pN_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal
pN_we  in  1  1=store, 0=load
pN_se  in  1  sign-extend for loads
pN_rvalid  out  1  one-cycle response pulse
pN_rdata  out  DW  load data; valid only while pN_rvalid=1
pN_err  out  1  error flag; valid only while pN_rvalid=1
ram_a  out  AW  RAM address
ram_di  out  DW  RAM write data
ram_size  out  2  RAM size code
ram_rw  out  1  RAM direction: 0=read, 1=write
ram_e  out  1  RAM enable
ram_se  out  1  RAM sign-extend
ram_do  in  DW  RAM read data (combinational from RAM)
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Single clock domain, clk. Asynchronous active-low reset, rst_n.
- Reset values: state=IDLE; all outputs 0, including ram_a, ram_di, ram_size, ram_rw, ram_e, ram_se, both acks, both rvalids, both errs, and busy.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any pN_req is high, select one port per the arbitration rule.
  - Assert that port's pN_ack for this one cycle.
  - Latch addr, wdata, size, we, se and the port id.
  - If the request is legal, go to ACCESS. If it is illegal, go to DONE with err=1.
- Illegal request: size=11; halfword with addr[0]=1; word with addr[1:0]!=00.
  - Illegal requests never assert ram_e.
- ACCESS (exactly 1 cycle):
  - ram_e=1; ram_a, ram_di, ram_size, ram_se come from the latched values; ram_rw=latched we.
  - On a load, ram_do is captured into the rdata register at the clock edge ending ACCESS.
  - Next state: DONE.
- DONE (1 cycle):
  - The granted port's pN_rvalid=1.
  - pN_rdata = captured data for loads; 0 for stores and errors.
  - pN_err = latched error flag.
  - The other port's rvalid stays 0.
  - Next state: IDLE.
- Latency: ack in cycle T, RAM enabled in T+1, rvalid in T+2.
  - Error path: ack in T, rvalid in T+1.
  - Peak throughput: one access per 3 cycles.
- ram_e is 0 in IDLE and DONE.
  - ram_rw is driven to 0 whenever ram_e=0, so a store can never be reissued.
  - ram_a, ram_di, ram_size, ram_se hold their last values.
  - All RAM outputs come straight from flops, with no combinational path from pN_* inputs.
- Requests are never accepted outside IDLE. A pN_req still high when the FSM returns to IDLE is treated as a new request.
- Default arbitration (macro undefined): fixed priority, port 0 wins a simultaneous request.
- Reset asserted mid-operation: the FSM returns to IDLE and ram_e and ram_rw go to 0 immediately (asynchronously). The pending transaction is dropped and no rvalid is issued for it.
- No address-range check is needed: an aligned access never exceeds the top byte address.

Optional Feature:
DMEM_ARB_RR_EN
- Defined: round-robin arbitration.
  - A 1-bit last_grant register (reset 1) is updated on every ack.
  - On a simultaneous request, the port not granted last wins.
  - First contention after reset goes to port 0.
- Undefined: fixed priority (port 0 wins). last_grant is not implemented.

Test Plan:
- p0 store word addr=0x010, wdata=0xDEADBEEF, then p0 load word addr=0x010 -> store: ram_e high 1 cycle with ram_rw=1; load: rvalid at T+2, rdata=0xDEADBEEF, err=0.
- Store byte 0x80 to addr 0x021, then load byte addr=0x021 with se=1 and again with se=0 -> rdata=0xFFFFFF80, then 0x00000080.
- p1 load halfword addr=0x033 -> ack, rvalid at T+1 with err=1 and rdata=0; ram_e never asserted. Repeat with size=11 at addr=0x040 -> same response.
- p0 and p1 request in the same cycle, continuously, for 4 grants -> fixed priority: p0 granted every time. With DMEM_ARB_RR_EN: grant order p0, p1, p0, p1.
- p1 store word addr=0x100 -> drop rst_n during ACCESS: ram_e and ram_rw fall immediately, no rvalid, busy=0. After release, load word addr=0x100 -> no hang; response arrives with err=0.
